// File: rtl/de_scoreboard_regfile.sv
// Decode-stage register file with a per-register pending-writer scoreboard and stall generation.
// Optional WB_BYPASS_EN: forward WB data to read ports and let retiring/squashed writers clear stalls in the same cycle.
module de_scoreboard_regfile #(
    parameter int DBITS     = 32,
    parameter int REGWORDS  = 32,
    parameter int REGNOBITS = 5,
    parameter int RD_PORTS  = 2,
    parameter int PEND_BITS = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [RD_PORTS-1:0]           rd_en,
    input  logic [RD_PORTS*REGNOBITS-1:0] rd_addr,
    output logic [RD_PORTS*DBITS-1:0]     rd_data,
    input  logic                          issue_valid,
    input  logic                          issue_wr,
    input  logic [REGNOBITS-1:0]          issue_rd,
    input  logic                          squash_valid,
    input  logic [REGNOBITS-1:0]          squash_rd,
    input  logic                          wb_valid,
    input  logic [REGNOBITS-1:0]          wb_rd,
    input  logic [DBITS-1:0]              wb_data,
    output logic                          stall,
    output logic [REGWORDS-1:0]           busy_vec,
    output logic                          pend_err
);
    localparam int PMAX = (1 << PEND_BITS) - 1;

    logic [DBITS-1:0]     r_regs [REGWORDS];
    logic [PEND_BITS-1:0] r_pend [REGWORDS];
    logic [PEND_BITS-1:0] w_pend_nxt [REGWORDS];
    logic [REGWORDS-1:0]  r_busy, w_busy_nxt;
    logic [REGWORDS-1:0]  w_inc, w_wb, w_sq, w_eff_busy, w_ovf;
    logic                 r_err;
    logic                 w_wb_ok, w_sq_ok, w_iss_ok, w_full_stall;
    logic [RD_PORTS-1:0]  w_port_stall;

    assign w_wb_ok      = wb_valid && (wb_rd != '0);
    assign w_sq_ok      = squash_valid && (squash_rd != '0);
    assign w_full_stall = issue_valid && issue_wr && (issue_rd != '0) &&
                          (r_pend[issue_rd] == PEND_BITS'(PMAX));
    assign stall        = (|w_port_stall) || w_full_stall;
    // Issue is only counted when DE actually advances.
    assign w_iss_ok     = issue_valid && issue_wr && (issue_rd != '0) && !stall;

    for (genvar r = 0; r < REGWORDS; r++) begin : g_reg
        assign w_inc[r] = w_iss_ok && (issue_rd == REGNOBITS'(r));
        assign w_wb[r]  = w_wb_ok  && (wb_rd == REGNOBITS'(r));
        assign w_sq[r]  = w_sq_ok  && (squash_rd == REGNOBITS'(r));
`ifdef WB_BYPASS_EN
        assign w_eff_busy[r] = (int'(r_pend[r]) - int'(w_wb[r]) - int'(w_sq[r])) > 0;
`else
        assign w_eff_busy[r] = (r_pend[r] != '0);
`endif
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_port
        logic [REGNOBITS-1:0] w_addr;
        assign w_addr = rd_addr[i*REGNOBITS +: REGNOBITS];
        assign w_port_stall[i] = rd_en[i] && (w_addr != '0) && w_eff_busy[w_addr];
`ifdef WB_BYPASS_EN
        assign rd_data[i*DBITS +: DBITS] = (w_wb_ok && (wb_rd == w_addr)) ? wb_data : r_regs[w_addr];
`else
        assign rd_data[i*DBITS +: DBITS] = r_regs[w_addr];
`endif
    end

    // Deltas from issue, WB and squash are summed, then clamped into [0, PMAX].
    always_comb begin
        int s;
        s          = 0;
        w_ovf      = '0;
        w_busy_nxt = '0;
        for (int r = 0; r < REGWORDS; r++) begin
            s = int'(r_pend[r]) + int'(w_inc[r]) - int'(w_wb[r]) - int'(w_sq[r]);
            w_pend_nxt[r] = PEND_BITS'(s);
            if (s > PMAX) begin
                w_pend_nxt[r] = PEND_BITS'(PMAX);
                w_ovf[r]      = 1'b1;
            end else if (s < 0) begin
                w_pend_nxt[r] = '0;
                w_ovf[r]      = 1'b1;
            end
            w_busy_nxt[r] = (w_pend_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < REGWORDS; r++) begin
                r_regs[r] <= '0;
                r_pend[r] <= '0;
            end
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wb_ok) r_regs[wb_rd] <= wb_data;
            for (int r = 0; r < REGWORDS; r++) r_pend[r] <= w_pend_nxt[r];
            r_busy <= w_busy_nxt;
            r_err  <= r_err | (|w_ovf);
        end
    end

    assign busy_vec = r_busy;
    assign pend_err = r_err;

endmodule
